// File: rtl/csi2tx_ahb_decmux_if.sv
// AHB decoder/mux bus bundle: master-side address/control plus flattened slave responses.
// The 'slave' modport is the decoder's view; 'master' is the driver/observer view.
interface csi2tx_ahb_decmux_if #(
  parameter int unsigned NUM_SLV = 3,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic [ADDR_W-1:0]         haddr;
  logic [1:0]                htrans;
  logic [NUM_SLV-1:0]        hsel;
  logic [NUM_SLV*DATA_W-1:0] hrdata_s;
  logic [NUM_SLV-1:0]        hreadyout_s;
  logic [NUM_SLV*2-1:0]      hresp_s;
  logic [DATA_W-1:0]         hrdata;
  logic                      hready;
  logic [1:0]                hresp;

  modport master (
    output haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
    input  hsel, hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
    output hsel, hrdata, hready, hresp
  );
endinterface

// File: rtl/csi2tx_ahb_decmux.sv
// AHB address decoder + response mux with an internal ERROR-returning default slave.
// Optional error logging (err_cnt/err_addr) enabled by CSI2TX_AHB_DECMUX_ERRLOG_EN.
module csi2tx_ahb_decmux #(
  parameter int unsigned NUM_SLV = 3,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE  = {32'h0001_0000, 32'h0000_3004, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_LIMIT = {32'h0001_FFFF, 32'h0000_6000, 32'h0000_007C}
) (
  input  logic                hclk,
  input  logic                hresetn,
  csi2tx_ahb_decmux_if.slave  bus
`ifdef CSI2TX_AHB_DECMUX_ERRLOG_EN
  ,
  output logic [7:0]          err_cnt,
  output logic [ADDR_W-1:0]   err_addr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_SLV:0]     dsel_q, dsel_d;
  logic [NUM_SLV-1:0]   hit;
  logic [NUM_SLV-1:0]   hsel_c;
  logic                 found;
  logic                 def_sel;
  logic                 xfer_req;
  logic                 err_req;
  logic                 def_hreadyout;
  logic [1:0]           def_hresp;
  logic [DATA_W-1:0]    hrdata_c;
  logic                 hready_c;
  logic [1:0]           hresp_c;

  // Lowest-index hit wins; empty regions (base > limit) can never hit.
  always_comb begin
    hit    = '0;
    hsel_c = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      hit[i] = (bus.haddr >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
               (bus.haddr <= SLV_LIMIT[i*ADDR_W +: ADDR_W]);
      if (hit[i] && !found) begin
        hsel_c[i] = 1'b1;
        found     = 1'b1;
      end
    end
    def_sel = ~|hit;
  end

  assign bus.hsel = hsel_c;
  assign xfer_req = (bus.htrans == 2'b10) || (bus.htrans == 2'b11);

  // Default slave outputs depend on state only, keeping them out of the err_req path.
  assign def_hreadyout = (state_q != S_ERR1);
  assign def_hresp     = (state_q == S_IDLE) ? 2'b00 : 2'b01;

  always_comb begin
    hrdata_c = '0;
    hready_c = def_hreadyout;
    hresp_c  = def_hresp;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (dsel_q[i]) begin
        hrdata_c = bus.hrdata_s[i*DATA_W +: DATA_W];
        hready_c = bus.hreadyout_s[i];
        hresp_c  = bus.hresp_s[i*2 +: 2];
      end
    end
  end

  assign bus.hrdata = hrdata_c;
  assign bus.hready = hready_c;
  assign bus.hresp  = hresp_c;

  assign err_req = def_sel & xfer_req & hready_c;

  always_comb begin
    dsel_d = dsel_q;
    if (hready_c) begin
      dsel_d = {def_sel, hsel_c};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (err_req) state_d = S_ERR1;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = err_req ? S_ERR1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      dsel_q  <= {1'b1, {NUM_SLV{1'b0}}};
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
    end
  end

`ifdef CSI2TX_AHB_DECMUX_ERRLOG_EN
  logic              err_go;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  // ERR1 holds hready low, so this is exactly the set of transitions into ERR1.
  assign err_go = err_req && (state_q != S_ERR1);

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (err_go) begin
      err_addr_d = bus.haddr;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_csi2tx_ahb_decmux.sv
// Directed self-checking bench for csi2tx_ahb_decmux (default map plus an overlapping-region build).
// Error-log checks compile in when CSI2TX_AHB_DECMUX_ERRLOG_EN is defined.
module tb_csi2tx_ahb_decmux;
  logic hclk = 1'b0;
  logic hresetn;
  int   errors = 0;
  int   checks = 0;

  csi2tx_ahb_decmux_if #(.NUM_SLV(3), .ADDR_W(32), .DATA_W(32)) bus ();
  csi2tx_ahb_decmux_if #(.NUM_SLV(3), .ADDR_W(32), .DATA_W(32)) bus_o ();

`ifdef CSI2TX_AHB_DECMUX_ERRLOG_EN
  logic [7:0]  err_cnt, err_cnt_o;
  logic [31:0] err_addr, err_addr_o;
`endif

  csi2tx_ahb_decmux #(.NUM_SLV(3), .ADDR_W(32), .DATA_W(32)) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .bus      (bus)
`ifdef CSI2TX_AHB_DECMUX_ERRLOG_EN
    ,
    .err_cnt  (err_cnt),
    .err_addr (err_addr)
`endif
  );

  csi2tx_ahb_decmux #(
    .NUM_SLV   (3),
    .ADDR_W    (32),
    .DATA_W    (32),
    .SLV_BASE  ({32'h0001_0000, 32'h0000_0000, 32'h0000_0000}),
    .SLV_LIMIT ({32'h0001_FFFF, 32'h0000_00FF, 32'h0000_007C})
  ) dut_o (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .bus      (bus_o)
`ifdef CSI2TX_AHB_DECMUX_ERRLOG_EN
    ,
    .err_cnt  (err_cnt_o),
    .err_addr (err_addr_o)
`endif
  );

  always #5 hclk = ~hclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    hresetn = 1'b1;
    bus.haddr = 32'h0000_0040; bus.htrans = 2'b00;
    bus.hrdata_s = '0; bus.hreadyout_s = 3'b111; bus.hresp_s = '0;
    bus_o.haddr = '0; bus_o.htrans = 2'b00;
    bus_o.hrdata_s = '0; bus_o.hreadyout_s = 3'b111; bus_o.hresp_s = '0;
    #1 hresetn = 1'b0;
    #2;
    checks++; if (bus.hsel !== 3'b001) begin errors++; $display("FAIL reset_hsel: got %b expected %b", bus.hsel, 3'b001); end
    checks++; if (bus.hready !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b expected 1", bus.hready); end
    checks++; if (bus.hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b expected 00", bus.hresp); end
    checks++; if (bus.hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 0", bus.hrdata); end
    @(negedge hclk); @(negedge hclk);
    hresetn = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] addrs [12];
    logic [2:0]  exps  [12];
    addrs = '{32'h0000_0040, 32'h0000_3004, 32'h0000_6000, 32'h0001_8000, 32'h0000_007C, 32'h0000_0080,
              32'h0000_3003, 32'h0000_6001, 32'h0001_FFFF, 32'h0002_0000, 32'h0000_1000, 32'h0000_0000};
    exps  = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b001, 3'b000,
              3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001};
    for (int k = 0; k < 12; k++) begin
      @(negedge hclk);
      bus.haddr = addrs[k]; bus.htrans = 2'b00;
      #1;
      checks++;
      if (bus.hsel !== exps[k]) begin
        errors++; $display("FAIL decode_%h: got %b expected %b", addrs[k], bus.hsel, exps[k]);
      end
    end
  endtask

  task automatic test_unmapped_error();
    @(negedge hclk);
    bus.haddr = 32'h0000_1000; bus.htrans = 2'b10;
    @(negedge hclk);
    bus.htrans = 2'b00;
    checks++; if ({bus.hready, bus.hresp} !== 3'b001) begin errors++; $display("FAIL err1_cycle: got %b expected 001", {bus.hready, bus.hresp}); end
    checks++; if (bus.hrdata !== 32'h0) begin errors++; $display("FAIL err1_hrdata: got %h expected 0", bus.hrdata); end
    @(negedge hclk);
    checks++; if ({bus.hready, bus.hresp} !== 3'b101) begin errors++; $display("FAIL err2_cycle: got %b expected 101", {bus.hready, bus.hresp}); end
    @(negedge hclk);
    checks++; if ({bus.hready, bus.hresp} !== 3'b100) begin errors++; $display("FAIL err_return_okay: got %b expected 100", {bus.hready, bus.hresp}); end
  endtask

  task automatic test_idle_unmapped();
    @(negedge hclk);
    bus.haddr = 32'h0000_1000; bus.htrans = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      checks++;
      if ({bus.hready, bus.hresp} !== 3'b100) begin
        errors++; $display("FAIL idle_unmapped_%0d: got %b expected 100", k, {bus.hready, bus.hresp});
      end
    end
    bus.htrans = 2'b01;
    @(negedge hclk);
    checks++; if ({bus.hready, bus.hresp} !== 3'b100) begin errors++; $display("FAIL busy_unmapped: got %b expected 100", {bus.hready, bus.hresp}); end
    bus.htrans = 2'b00;
  endtask

  task automatic test_back_to_back();
    @(negedge hclk);
    bus.haddr = 32'h0000_1000; bus.htrans = 2'b10;
    @(negedge hclk);
    checks++; if ({bus.hready, bus.hresp} !== 3'b001) begin errors++; $display("FAIL b2b_first_err1: got %b expected 001", {bus.hready, bus.hresp}); end
    @(negedge hclk);
    checks++; if ({bus.hready, bus.hresp} !== 3'b101) begin errors++; $display("FAIL b2b_first_err2: got %b expected 101", {bus.hready, bus.hresp}); end
    bus.haddr = 32'h0000_1004; bus.htrans = 2'b11;
    @(negedge hclk);
    checks++; if ({bus.hready, bus.hresp} !== 3'b001) begin errors++; $display("FAIL b2b_second_err1: got %b expected 001", {bus.hready, bus.hresp}); end
    bus.htrans = 2'b00;
    @(negedge hclk);
    checks++; if ({bus.hready, bus.hresp} !== 3'b101) begin errors++; $display("FAIL b2b_second_err2: got %b expected 101", {bus.hready, bus.hresp}); end
    @(negedge hclk);
    checks++; if ({bus.hready, bus.hresp} !== 3'b100) begin errors++; $display("FAIL b2b_okay: got %b expected 100", {bus.hready, bus.hresp}); end
  endtask

  task automatic test_wait_state();
    @(negedge hclk);
    bus.hrdata_s    = {32'hCCCC_2222, 32'hBBBB_1111, 32'hAAAA_0000};
    bus.hreadyout_s = 3'b111;
    bus.hresp_s     = {2'b00, 2'b00, 2'b00};
    bus.haddr = 32'h0000_3004; bus.htrans = 2'b10;
    @(negedge hclk);
    bus.hreadyout_s = 3'b101;
    bus.haddr = 32'h0000_0010;
    #1;
    checks++; if (bus.hsel !== 3'b001) begin errors++; $display("FAIL wait_hsel: got %b expected 001", bus.hsel); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.hrdata !== 32'hBBBB_1111 || bus.hready !== 1'b0) begin
        errors++; $display("FAIL wait_hold_%0d: got %h/%b expected bbbb1111/0", k, bus.hrdata, bus.hready);
      end
      @(negedge hclk);
    end
    bus.hreadyout_s = 3'b111;
    #1;
    checks++; if (bus.hrdata !== 32'hBBBB_1111 || bus.hready !== 1'b1) begin errors++; $display("FAIL wait_release: got %h/%b expected bbbb1111/1", bus.hrdata, bus.hready); end
    @(negedge hclk);
    bus.htrans = 2'b00;
    checks++; if (bus.hrdata !== 32'hAAAA_0000) begin errors++; $display("FAIL wait_switch_slv0: got %h expected aaaa0000", bus.hrdata); end
    bus.hresp_s = {2'b00, 2'b00, 2'b01};
    #1;
    checks++; if (bus.hresp !== 2'b01) begin errors++; $display("FAIL slv0_hresp_mux: got %b expected 01", bus.hresp); end
    bus.hresp_s = '0;
  endtask

  task automatic test_overlap();
    bus_o.haddr = 32'h0000_0010; #1;
    checks++; if (bus_o.hsel !== 3'b001) begin errors++; $display("FAIL overlap_0010: got %b expected 001", bus_o.hsel); end
    bus_o.haddr = 32'h0000_0080; #1;
    checks++; if (bus_o.hsel !== 3'b010) begin errors++; $display("FAIL overlap_0080: got %b expected 010", bus_o.hsel); end
    bus_o.haddr = 32'h0000_0100; #1;
    checks++; if (bus_o.hsel !== 3'b000) begin errors++; $display("FAIL overlap_0100: got %b expected 000", bus_o.hsel); end
  endtask

`ifdef CSI2TX_AHB_DECMUX_ERRLOG_EN
  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic xfer(input logic [31:0] a, input logic [1:0] t);
    int unsigned n;
    n = 0;
    bus.haddr = a; bus.htrans = t;
    while (bus.hready !== 1'b1 && n < 16) begin
      @(negedge hclk);
      n++;
    end
    if (n >= 16) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: hready stuck at %b, expected 1 within 16 cycles", bus.hready);
    end
    @(negedge hclk);
  endtask

  task automatic test_errlog();
    @(negedge hclk);
    bus.htrans = 2'b00;
    hresetn = 1'b0;
    @(negedge hclk);
    hresetn = 1'b1;
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL errlog_reset_cnt: got %h expected 00", err_cnt); end
    for (int i = 0; i < 300; i++) begin
      xfer(32'h0000_1000 + 32'(i) * 32'd4, 2'b10);
      if (i == 253) begin
        checks++; if (err_cnt !== 8'hFE) begin errors++; $display("FAIL errlog_cnt_254: got %h expected fe", err_cnt); end
      end
      if (i == 0) begin
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL errlog_cnt_1: got %h expected 01", err_cnt); end
      end
    end
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL errlog_cnt_sat: got %h expected ff", err_cnt); end
    checks++; if (err_addr !== 32'h0000_14AC) begin errors++; $display("FAIL errlog_addr: got %h expected 000014ac", err_addr); end
    checks++; if ({bus.hready, bus.hresp} !== 3'b001) begin errors++; $display("FAIL errlog_in_err1: got %b expected 001", {bus.hready, bus.hresp}); end
    #2 hresetn = 1'b0;
    #1;
    checks++; if ({bus.hready, bus.hresp} !== 3'b100) begin errors++; $display("FAIL errlog_rst_bus: got %b expected 100", {bus.hready, bus.hresp}); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL errlog_rst_cnt: got %h expected 00", err_cnt); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL errlog_rst_addr: got %h expected 0", err_addr); end
    bus.htrans = 2'b00;
    @(negedge hclk);
    hresetn = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_unmapped_error();
    test_idle_unmapped();
    test_back_to_back();
    test_wait_state();
    test_overlap();
`ifdef CSI2TX_AHB_DECMUX_ERRLOG_EN
    test_errlog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
